// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-ported VRAM between video scan-out and a CPU draw engine.
// Video always owns the port when it asks for it. The CPU gets read, write
// and XOR (read-modify-write with a collision flag) operations. An optional
// full-screen clear walks every address and writes zero.
//
// Build option:
//   VRAM_CLEAR_EN - when defined, the clear engine (CLR state plus a 13-bit
//                   address counter) is built. When undefined, clr_req is
//                   ignored and clr_busy is tied low.
//
// Ports:
//   clk, reset              - clock and asynchronous active-high reset
//   vid_req                 - video wants a read this cycle
//   vid_hpos, vid_vpos      - video read coordinate
//   vid_pixel               - pixel for the previous cycle's video read, else 0
//   cpu_req                 - draw request, held until cpu_ack
//   cpu_op                  - 00 read, 01 write, 10 XOR, 11 read
//   cpu_hpos, cpu_vpos      - draw coordinate
//   cpu_wdata               - draw data
//   cpu_ack                 - one-cycle completion pulse
//   cpu_rdata               - old pixel value seen by read / XOR
//   cpu_collision           - XOR hit a set bit of the old pixel
//   clr_req, clr_busy       - clear start pulse and clear-in-progress flag
//   mem_hpos, mem_vpos      - VRAM address
//   mem_we, mem_wdata       - VRAM write strobe and data
//   mem_rdata               - VRAM read data, one cycle after the address
// ---------------------------------------------------------------------------
module vram_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       vid_req,
    input  logic [6:0] vid_hpos,
    input  logic [5:0] vid_vpos,
    output logic [1:0] vid_pixel,
    input  logic       cpu_req,
    input  logic [1:0] cpu_op,
    input  logic [6:0] cpu_hpos,
    input  logic [5:0] cpu_vpos,
    input  logic [1:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [1:0] cpu_rdata,
    output logic       cpu_collision,
    input  logic       clr_req,
    output logic       clr_busy,
    output logic [6:0] mem_hpos,
    output logic [5:0] mem_vpos,
    output logic       mem_we,
    output logic [1:0] mem_wdata,
    input  logic [1:0] mem_rdata
);

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_XOR   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        ACK,
        CLR
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [1:0] op_q;
    logic [6:0] hpos_q;
    logic [5:0] vpos_q;
    logic [1:0] wdata_q;
    logic       vid_q;
    logic       clear_start;
    logic       cpu_accept;

`ifdef VRAM_CLEAR_EN
    logic [12:0] clr_addr;

    // A clear can only start from IDLE, so a request arriving while busy
    // or mid-operation simply falls on the floor.
    assign clear_start = clr_req;
    assign clr_busy    = (state == CLR);

    // Linear clear address; it wraps back to 0 after the last pixel, which
    // leaves it ready for the next clear without an explicit reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_addr <= 13'd0;
        end else if (state == CLR && !vid_req) begin
            clr_addr <= clr_addr + 13'd1;
        end
    end
`else
    // Clear engine absent: the request input is kept on the port but is
    // masked off so it can never start anything.
    assign clear_start = clr_req & 1'b0;
    assign clr_busy    = 1'b0;
`endif

    // Clear beats a simultaneous CPU request; the CPU keeps its request
    // high and is picked up when the FSM returns to IDLE.
    assign cpu_accept = (state == IDLE) && !clear_start && cpu_req;

    // State register plus the CPU operand latches and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_q          <= 2'b00;
            hpos_q        <= 7'd0;
            vpos_q        <= 6'd0;
            wdata_q       <= 2'b00;
            vid_q         <= 1'b0;
            cpu_rdata     <= 2'b00;
            cpu_collision <= 1'b0;
        end else begin
            state <= state_next;
            vid_q <= vid_req;
            if (cpu_accept) begin
                op_q          <= cpu_op;
                hpos_q        <= cpu_hpos;
                vpos_q        <= cpu_vpos;
                wdata_q       <= cpu_wdata;
                cpu_collision <= 1'b0;
            end
            // The read issued in the last RD cycle lands here; for XOR the
            // write data is rebuilt in place so WR can reuse the same path.
            if (state == CAP) begin
                cpu_rdata <= mem_rdata;
                if (op_q == OP_XOR) begin
                    wdata_q       <= mem_rdata ^ wdata_q;
                    cpu_collision <= |(mem_rdata & wdata_q);
                end
            end
        end
    end

    // Next-state logic. RD and WR hold while video owns the port so the
    // access is retried on the first free cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_next = CLR;
                end else if (cpu_req) begin
                    state_next = (cpu_op == OP_WRITE) ? WR : RD;
                end
            end
            RD: begin
                if (!vid_req) begin
                    state_next = CAP;
                end
            end
            CAP: begin
                state_next = (op_q == OP_XOR) ? WR : ACK;
            end
            WR: begin
                if (!vid_req) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
`ifdef VRAM_CLEAR_EN
            CLR: begin
                if (!vid_req && clr_addr == 13'h1fff) begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory port mux. Video overrides everything, which is what makes the
    // RD/WR stall states safe: the FSM never sees its access go through
    // while vid_req is high.
    always_comb begin
        mem_hpos  = hpos_q;
        mem_vpos  = vpos_q;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        if (vid_req) begin
            mem_hpos = vid_hpos;
            mem_vpos = vid_vpos;
        end else begin
            case (state)
                WR: begin
                    mem_we = 1'b1;
                end
`ifdef VRAM_CLEAR_EN
                CLR: begin
                    {mem_vpos, mem_hpos} = clr_addr;
                    mem_we               = 1'b1;
                    mem_wdata            = 2'b00;
                end
`endif
                default: begin
                    mem_we = 1'b0;
                end
            endcase
        end
    end

    assign cpu_ack   = (state == ACK);
    assign vid_pixel = vid_q ? mem_rdata : 2'b00;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//
// Self-checking bench for vram_arbiter. A behavioural VRAM (one-cycle read
// latency) sits on the memory port; a separate pixel array holds the
// expected screen contents, updated from the operation rules. Video reads
// target the upper half of the screen and CPU ops the lower half so the
// expected video pixel is always known. Completion latency is predicted by
// counting which cycles leave the port free for the CPU accesses.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vid_req = 1'b0;
    logic [6:0] vid_hpos = 7'd0;
    logic [5:0] vid_vpos = 6'd0;
    logic [1:0] vid_pixel;
    logic       cpu_req = 1'b0;
    logic [1:0] cpu_op = 2'b00;
    logic [6:0] cpu_hpos = 7'd0;
    logic [5:0] cpu_vpos = 6'd0;
    logic [1:0] cpu_wdata = 2'b00;
    logic       cpu_ack;
    logic [1:0] cpu_rdata;
    logic       cpu_collision;
    logic       clr_req = 1'b0;
    logic       clr_busy;
    logic [6:0] mem_hpos;
    logic [5:0] mem_vpos;
    logic       mem_we;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata;

    vram_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .vid_req      (vid_req),
        .vid_hpos     (vid_hpos),
        .vid_vpos     (vid_vpos),
        .vid_pixel    (vid_pixel),
        .cpu_req      (cpu_req),
        .cpu_op       (cpu_op),
        .cpu_hpos     (cpu_hpos),
        .cpu_vpos     (cpu_vpos),
        .cpu_wdata    (cpu_wdata),
        .cpu_ack      (cpu_ack),
        .cpu_rdata    (cpu_rdata),
        .cpu_collision(cpu_collision),
        .clr_req      (clr_req),
        .clr_busy     (clr_busy),
        .mem_hpos     (mem_hpos),
        .mem_vpos     (mem_vpos),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural VRAM with a bench-side preload port.
    logic [1:0]  vram [0:8191];
    logic        tbWe = 1'b0;
    logic [12:0] tbAddr = 13'd0;
    logic [1:0]  tbData = 2'b00;

    always @(posedge clk) begin
        if (mem_we) begin
            vram[{mem_vpos, mem_hpos}] <= mem_wdata;
        end else if (tbWe) begin
            vram[tbAddr] <= tbData;
        end
        mem_rdata <= vram[{mem_vpos, mem_hpos}];
    end

    logic [1:0]  model [0:8191];

    int          passCount = 0;
    int          failCount = 0;
    int          checkCount = 0;
    logic        prevVid = 1'b0;
    logic [12:0] prevAddr = 13'd0;
    int          weCount = 0;
    logic [12:0] lastWeAddr = 13'd0;
    logic [1:0]  lastWdata = 2'b00;
    logic        sawAck = 1'b0;
    logic        sawBusy = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First cycle at or after 'from' where video leaves the port free.
    function automatic int firstFree(input logic [63:0] pat, input int from);
        int t;
        t = from;
        while (t < 64 && pat[t]) t++;
        return t;
    endfunction

    // Ack cycle, counted from the cycle the request is sampled (cycle 0).
    // Each access needs one free port cycle; XOR needs a capture cycle
    // between its read and its write.
    function automatic int expectedLatency(input logic [1:0] op, input logic [63:0] pat);
        int a;
        int b;
        a = firstFree(pat, 1);
        if (op == 2'b01) return a + 1;
        if (op != 2'b10) return a + 2;
        b = firstFree(pat, a + 2);
        return b + 1;
    endfunction

    task automatic setVid(input logic on);
        vid_req  = on;
        vid_hpos = 7'($urandom);
        vid_vpos = {1'b1, 5'($urandom)};
    endtask

    // One clock: checks on the falling edge, then return 1 ns after the
    // next rising edge, where the caller drives new inputs.
    task automatic doCycle();
        @(negedge clk);
        if (vid_req) begin
            checkOutput("vid_no_we", 32'(mem_we), 32'd0);
            checkOutput("vid_addr", 32'({mem_vpos, mem_hpos}), 32'({vid_vpos, vid_hpos}));
        end
        if (prevVid) checkOutput("vid_pixel", 32'(vid_pixel), 32'(model[prevAddr]));
        else checkOutput("vid_pixel_idle", 32'(vid_pixel), 32'd0);
        if (mem_we) begin
            weCount++;
            lastWeAddr = {mem_vpos, mem_hpos};
            lastWdata  = mem_wdata;
        end
        sawAck  = cpu_ack;
        sawBusy = clr_busy;
        @(posedge clk);
        prevVid  = vid_req && !reset;
        prevAddr = {vid_vpos, vid_hpos};
        #1;
    endtask

    // Fill VRAM and the expected screen with random pixels, reset held.
    task automatic preload();
        logic [1:0] d;
        reset   = 1'b1;
        prevVid = 1'b0;
        for (int i = 0; i < 8192; i++) begin
            d         = 2'($urandom);
            tbWe      = 1'b1;
            tbAddr    = 13'(i);
            tbData    = d;
            model[i]  = d;
            @(posedge clk);
            #1;
        end
        tbWe = 1'b0;
    endtask

    task automatic checkVram(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 8192; i++) begin
            if (vram[i] !== model[i]) bad++;
        end
        checkOutput(tag, 32'(bad), 32'd0);
    endtask

    // One CPU operation against a video pattern (bit n = vid_req in cycle n).
    task automatic applyStimulus(input logic [1:0] op, input logic [6:0] h, input logic [5:0] v,
                                 input logic [1:0] wd, input logic [63:0] vidPat);
        int          lat;
        int          expLat;
        logic [12:0] addr;
        logic [1:0]  old;
        logic [1:0]  expNew;
        logic        expColl;
        addr    = {v, h};
        old     = model[addr];
        expLat  = expectedLatency(op, vidPat);
        expNew  = old;
        expColl = 1'b0;
        if (op == 2'b01) expNew = wd;
        if (op == 2'b10) begin
            expNew  = old ^ wd;
            expColl = |(old & wd);
        end
        cpu_req   = 1'b1;
        cpu_op    = op;
        cpu_hpos  = h;
        cpu_vpos  = v;
        cpu_wdata = wd;
        weCount   = 0;
        lat       = -1;
        for (int n = 0; n < 200; n++) begin
            setVid((n < 64) ? vidPat[n] : 1'b0);
            doCycle();
            clr_req = 1'b0;
            if (sawAck) begin
                lat = n;
                break;
            end
        end
        cpu_req = 1'b0;
        setVid(1'b0);
        checkOutput("ack_latency", 32'(lat), 32'(expLat));
        checkOutput("ack_pulse", 32'(cpu_ack), 32'd0);
        checkOutput("collision", 32'(cpu_collision), 32'(expColl));
        if (op != 2'b01) checkOutput("rdata", 32'(cpu_rdata), 32'(old));
        checkOutput("we_cycles", 32'(weCount), (op == 2'b01 || op == 2'b10) ? 32'd1 : 32'd0);
        if (weCount > 0) begin
            checkOutput("we_addr", 32'(lastWeAddr), 32'(addr));
            checkOutput("we_data", 32'(lastWdata), 32'(expNew));
        end
        model[addr] = expNew;
        checkOutput("vram_pixel", 32'(vram[addr]), 32'(expNew));
    endtask

    initial begin
        int          busyCount;
        int          ackAt;
        logic [63:0] pat;
        logic [12:0] a;

        $display("[TB] preload and reset");
        preload();
        checkOutput("rst_ack", 32'(cpu_ack), 32'd0);
        checkOutput("rst_rdata", 32'(cpu_rdata), 32'd0);
        checkOutput("rst_coll", 32'(cpu_collision), 32'd0);
        checkOutput("rst_busy", 32'(clr_busy), 32'd0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_pixel", 32'(vid_pixel), 32'd0);
        reset = 1'b0;
        doCycle();

        $display("[TB] directed operations");
        applyStimulus(2'b01, 7'd1, 6'd1, 2'd3, 64'd0);
        applyStimulus(2'b00, 7'd1, 6'd1, 2'd0, 64'd0);
        applyStimulus(2'b01, 7'd5, 6'd3, 2'd2, 64'd0);
        applyStimulus(2'b10, 7'd5, 6'd3, 2'd3, 64'd0);
        checkOutput("xor_result", 32'(model[{6'd3, 7'd5}]), 32'd1);
        applyStimulus(2'b10, 7'd9, 6'd7, 2'd2, 64'h3e);
        applyStimulus(2'b11, 7'd5, 6'd3, 2'd0, 64'h2);
        applyStimulus(2'b01, 7'd127, 6'd31, 2'd1, 64'h6);

        $display("[TB] randomized operations");
        for (int k = 0; k < 40; k++) begin
            pat = {$urandom & $urandom, $urandom & $urandom};
            applyStimulus(2'($urandom), 7'($urandom), 6'($urandom_range(31, 0)), 2'($urandom), pat);
            for (int j = 0; j < int'($urandom_range(2, 0)); j++) begin
                setVid(1'($urandom));
                doCycle();
            end
            setVid(1'b0);
        end

        $display("[TB] reset during read-modify-write");
        a         = {6'd4, 7'd10};
        cpu_req   = 1'b1;
        cpu_op    = 2'b10;
        cpu_hpos  = 7'd10;
        cpu_vpos  = 6'd4;
        cpu_wdata = 2'd1;
        doCycle();
        doCycle();
        reset   = 1'b1;
        cpu_req = 1'b0;
        #1;
        checkOutput("abort_ack", 32'(cpu_ack), 32'd0);
        checkOutput("abort_we", 32'(mem_we), 32'd0);
        checkOutput("abort_rdata", 32'(cpu_rdata), 32'd0);
        doCycle();
        reset = 1'b0;
        busyCount = 0;
        for (int n = 0; n < 4; n++) begin
            doCycle();
            if (sawAck) busyCount++;
        end
        checkOutput("abort_noack", 32'(busyCount), 32'd0);
        checkOutput("abort_pixel", 32'(vram[a]), 32'(model[a]));

`ifdef VRAM_CLEAR_EN
        $display("[TB] clear with simultaneous cpu request");
        clr_req   = 1'b1;
        cpu_req   = 1'b1;
        cpu_op    = 2'b01;
        cpu_hpos  = 7'd2;
        cpu_vpos  = 6'd2;
        cpu_wdata = 2'd1;
        busyCount = 0;
        ackAt     = -1;
        for (int n = 0; n < 9000; n++) begin
            doCycle();
            clr_req = 1'b0;
            if (sawBusy) busyCount++;
            if (sawAck) begin
                ackAt = n;
                break;
            end
        end
        cpu_req = 1'b0;
        checkOutput("clr_busy_cycles", 32'(busyCount), 32'd8192);
        checkOutput("clr_cpu_ack", 32'(ackAt), 32'd8195);
        for (int i = 0; i < 8192; i++) model[i] = 2'd0;
        model[{6'd2, 7'd2}] = 2'd1;
        checkVram("clr_contents");

        $display("[TB] reset during clear");
        preload();
        reset = 1'b0;
        doCycle();
        clr_req = 1'b1;
        doCycle();
        clr_req = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (clr_busy && mem_we && {mem_vpos, mem_hpos} == 13'd100) break;
            doCycle();
        end
        checkOutput("clr_at_100", 32'({mem_vpos, mem_hpos}), 32'd100);
        reset = 1'b1;
        #1;
        checkOutput("clr_abort_busy", 32'(clr_busy), 32'd0);
        doCycle();
        reset = 1'b0;
        doCycle();
        checkOutput("clr_abort_idle", 32'(sawBusy), 32'd0);
        for (int i = 0; i < 100; i++) model[i] = 2'd0;
        checkVram("clr_partial");
        applyStimulus(2'b10, 7'd20, 6'd1, 2'd3, 64'd0);
`else
        $display("[TB] clear request without clear engine");
        clr_req = 1'b1;
        busyCount = 0;
        for (int n = 0; n < 6; n++) begin
            doCycle();
            clr_req = 1'b0;
            if (sawBusy) busyCount++;
        end
        checkOutput("noclr_busy", 32'(busyCount), 32'd0);
        checkVram("noclr_vram");
        clr_req = 1'b1;
        applyStimulus(2'b01, 7'd3, 6'd2, 2'd2, 64'd0);
        clr_req = 1'b1;
        applyStimulus(2'b10, 7'd3, 6'd2, 2'd3, 64'd0);
        checkVram("noclr_vram_after");
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 vid_req  in  1  video scan-out wants a VRAM read this cycle (active display region).
REQ-004 vid_hpos  in  7 / vid_vpos  in  6  video read coordinate.
REQ-005 vid_pixel  out  2  video pixel, valid 1 cycle after the vid_req cycle; 0 otherwise.
REQ-006 cpu_req  in  1  draw request, held high until cpu_ack.
REQ-007 cpu_op  in  2  00 read, 01 write, 10 XOR, 11 treated as read.
REQ-008 cpu_hpos  in  7 / cpu_vpos  in  6 / cpu_wdata  in  2  draw operands.
REQ-009 cpu_ack  out  1  one-cycle completion pulse.
REQ-010 cpu_rdata  out  2 / cpu_collision  out  1  old pixel value, and the XOR collision flag.
REQ-011 clr_req  in  1 / clr_busy  out  1  full-screen clear start pulse, and clear-in-progress flag.
REQ-012 mem_hpos  out  7 / mem_vpos  out  6 / mem_we  out  1 / mem_wdata  out  2  single VRAM port.
REQ-013 mem_rdata  in  2  VRAM read data, 1-cycle latency from address.

Function
REQ-014 Video has absolute priority: when vid_req=1, mem address = vid coordinate, mem_we=0, whatever the FSM state.
REQ-015 vid_pixel = mem_rdata when vid_req was 1 in the previous cycle, else 0.
REQ-016 FSM states: IDLE, RD, CAP, WR, ACK, CLR.
REQ-017 IDLE: clr_req=1 -> CLR; else cpu_req=1 -> latch cpu_op/hpos/vpos/wdata, go to WR if op=write, else RD.
REQ-018 Simultaneous clr_req and cpu_req in IDLE: clear wins; CPU request stays pending and is accepted on return to IDLE.
REQ-019 RD: issue read at latched coordinate; stay in RD while vid_req=1; else -> CAP.
REQ-020 CAP: capture mem_rdata into cpu_rdata; read -> ACK; XOR -> WR with write data = old ^ wdata, cpu_collision = |(old & wdata).
REQ-021 WR: issue write (mem_we=1) of latched data; stay in WR while vid_req=1; else -> ACK.
REQ-022 ACK: cpu_ack=1 for exactly this cycle, -> IDLE; cpu_collision is 0 for read/write ops.
REQ-023 Latency with no video contention, counted from the cycle cpu_req is sampled in IDLE: write ack at +2, read +3, XOR +4; each vid_req cycle in RD/WR adds 1.
REQ-024 CLR: write 0 to the 13-bit linear address {vpos,hpos}, incrementing on each issued write, stalling on vid_req; after address 8191 is written -> IDLE; clr_busy=1 throughout CLR.
REQ-025 clr_req while clr_busy=1, or outside IDLE, is ignored; cpu_req outside IDLE is not sampled.
REQ-026 Coordinates wrap naturally within their widths; there is no out-of-range case.

Reset
REQ-027 reset forces IDLE, clear counter 0, cpu_ack 0, cpu_rdata 0, cpu_collision 0, clr_busy 0, mem_we 0, vid_pixel 0.
REQ-028 reset mid-clear or mid-RMW aborts without completing the write; no ack is issued for the aborted request.

Configuration
REQ-029 Macro VRAM_CLEAR_EN: when defined, CLR state and the clear counter exist as specified.
REQ-030 When VRAM_CLEAR_EN is undefined: clr_req is ignored, clr_busy is tied 0, and CLR is unreachable.

Verification
REQ-031 Write (1,1) value 3 with no vid_req -> ack at +2, mem_we for one cycle at +1 with mem_wdata=3.
REQ-032 Pixel=2, XOR wdata=3 -> new pixel 1, cpu_collision=1, cpu_rdata=2, ack at +4.
REQ-033 XOR during a 5-cycle vid_req burst covering RD -> ack at +9; video reads return correct pixels, mem_we never high while vid_req=1.
REQ-034 clr_req and cpu_req in the same cycle -> clr_busy for 8192 cycles (no video), then CPU op completes; all pixels read 0.
REQ-035 reset asserted at clear address 100 -> clr_busy=0 next edge; addresses 100..8191 keep prior contents.
REQ-036 Build without VRAM_CLEAR_EN, pulse clr_req -> clr_busy stays 0, VRAM unchanged, CPU ops unaffected.
